// File: rtl/serial_key_loader.sv
// Purpose : serial key loader; shifts in a KEY_SIZE-bit key MSB first plus an even-parity trailer and commits it atomically to key.
// Latency : key/key_ready/load_err update on the clock edge that samples the parity strobe, visible the following cycle.
// Backpressure: none; the sender strobes at will, and a frame stalled for TIMEOUT_CYCLES strobe-less cycles is aborted with load_err.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load_start            begin/restart a frame (wins over a simultaneous key_strobe)
//   key_strobe, key_bit   serial data bit valid this cycle
//   key, key_ready        committed key and "a key has been committed since reset"
//   busy, load_err        frame in progress; last frame failed (sticky until next start)
//   bit_count             data bits received in the current/last frame
//
// Optional build macro KEY_LOCK_EN: once a key is committed, load_start is ignored until reset.
module serial_key_loader #(
    parameter int KEY_SIZE       = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_start,
    input  logic                          key_strobe,
    input  logic                          key_bit,
    output logic [KEY_SIZE-1:0]           key,
    output logic                          key_ready,
    output logic                          busy,
    output logic                          load_err,
    output logic [$clog2(KEY_SIZE+1)-1:0] bit_count
);

    localparam int BW = $clog2(KEY_SIZE + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic [BW-1:0] LAST_BIT = BW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]          state_q, state_d;
    logic [KEY_SIZE-1:0] shreg_q, shreg_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]       idle_q, idle_d;
    logic                key_ready_q, key_ready_d;
    logic                load_err_q, load_err_d;
    logic                busy_q;
    logic                start_ok;

    // Once locked, a start request in IDLE is simply not seen.
`ifdef KEY_LOCK_EN
    assign start_ok = load_start && !key_ready_q;
`else
    assign start_ok = load_start;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        key_d       = key_q;
        bit_cnt_d   = bit_cnt_q;
        idle_d      = idle_q;
        key_ready_d = key_ready_q;
        load_err_d  = load_err_q;

        if (state_q == ST_IDLE) begin
            // key_strobe has no effect while idle
            if (start_ok) begin
                state_d    = ST_SHIFT;
                shreg_d    = '0;
                bit_cnt_d  = '0;
                idle_d     = '0;
                load_err_d = 1'b0;
            end
        end else if (load_start) begin
            // restart; any simultaneous strobe bit is dropped
            state_d    = ST_SHIFT;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            idle_d     = '0;
            load_err_d = 1'b0;
        end else if (key_strobe) begin
            idle_d = '0;
            if (state_q == ST_SHIFT) begin
                shreg_d   = {shreg_q[KEY_SIZE-2:0], key_bit};
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_PARITY;
                end
            end else begin
                // even parity over data plus trailer must come out zero
                if ((^shreg_q ^ key_bit) == 1'b0) begin
                    key_d       = shreg_q;
                    key_ready_d = 1'b1;
                    load_err_d  = 1'b0;
                end else begin
                    load_err_d  = 1'b1;
                end
                state_d = ST_IDLE;
            end
        end else if (idle_q == TO_LAST) begin
            // TIMEOUT_CYCLES-th consecutive strobe-less busy cycle
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
            idle_d     = '0;
        end else begin
            idle_d = idle_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            key_q       <= '0;
            bit_cnt_q   <= '0;
            idle_q      <= '0;
            key_ready_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            key_q       <= key_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_q      <= idle_d;
            key_ready_q <= key_ready_d;
            load_err_q  <= load_err_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign key       = key_q;
    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign load_err  = load_err_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_serial_key_loader.sv
// Purpose : directed self-checking bench for serial_key_loader (KEY_SIZE=6, TIMEOUT_CYCLES=8).
// Latency : results are sampled 1 time unit after the edge that consumed the stimulus.
// Backpressure: not applicable; the bench drives strobes directly.
module tb_serial_key_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic       key_strobe;
    logic       key_bit;
    logic [5:0] key;
    logic       key_ready;
    logic       busy;
    logic       load_err;
    logic [2:0] bit_count;

    int checks = 0;
    int errors = 0;

    serial_key_loader #(.KEY_SIZE(6), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .key_strobe (key_strobe),
        .key_bit    (key_bit),
        .key        (key),
        .key_ready  (key_ready),
        .busy       (busy),
        .load_err   (load_err),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        key_strobe = 1'b1;
        key_bit    = b;
        tick();
        key_strobe = 1'b0;
        key_bit    = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] data, input logic par);
        for (int i = 5; i >= 0; i--) send_bit(data[i]);
        send_bit(par);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (key !== 6'h00) begin errors++; $display("FAIL reset_key got=%h exp=00", key); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", load_err); end
        checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL reset_bitcnt got=%0d exp=0", bit_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_start got=%b exp=1", busy); end
        send_frame(6'b101101, 1'b0);
        checks++; if (key !== 6'h2D) begin errors++; $display("FAIL good_key got=%h exp=2d", key); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL good_ready got=%b exp=1", key_ready); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", load_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got=%b exp=0", busy); end
        checks++; if (bit_count !== 3'd6) begin errors++; $display("FAIL good_bitcnt got=%0d exp=6", bit_count); end
    endtask

    task automatic test_parity_error();
        do_start();
        send_frame(6'b000111, 1'b0);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL parerr_err got=%b exp=1", load_err); end
        checks++; if (key !== 6'h2D) begin errors++; $display("FAIL parerr_key got=%h exp=2d", key); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL parerr_ready got=%b exp=1", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parerr_busy got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        do_start();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL to_err_cleared got=%b exp=0", load_err); end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 7; i++) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_7 got=%b exp=1", busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL to_err_7 got=%b exp=0", load_err); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_8 got=%b exp=0", busy); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL to_err_8 got=%b exp=1", load_err); end
        checks++; if (key !== 6'h2D) begin errors++; $display("FAIL to_key got=%h exp=2d", key); end
        checks++; if (bit_count !== 3'd3) begin errors++; $display("FAIL to_bitcnt got=%0d exp=3", bit_count); end
    endtask

    task automatic test_restart();
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        checks++; if (bit_count !== 3'd4) begin errors++; $display("FAIL rs_bitcnt_4 got=%0d exp=4", bit_count); end
        load_start = 1'b1;
        key_strobe = 1'b1;
        key_bit    = 1'b1;
        tick();
        load_start = 1'b0;
        key_strobe = 1'b0;
        key_bit    = 1'b0;
        checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL rs_bitcnt_0 got=%0d exp=0", bit_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%b exp=1", busy); end
        send_frame(6'b110011, 1'b0);
        checks++; if (key !== 6'h33) begin errors++; $display("FAIL rs_key got=%h exp=33", key); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rs_err got=%b exp=0", load_err); end
    endtask

    task automatic test_mid_reset();
        do_start();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (key !== 6'h00) begin errors++; $display("FAIL mr_key got=%h exp=00", key); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL mr_ready got=%b exp=0", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%b exp=0", busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL mr_err got=%b exp=0", load_err); end
        checks++; if (bit_count !== 3'd0) begin errors++; $display("FAIL mr_bitcnt got=%0d exp=0", bit_count); end
        do_start();
        send_frame(6'b100000, 1'b1);
        checks++; if (key !== 6'h20) begin errors++; $display("FAIL mr_key_after got=%h exp=20", key); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL mr_ready_after got=%b exp=1", key_ready); end
    endtask

    task automatic test_reload_lock();
        logic [5:0] exp_key;
        logic       exp_busy;
`ifdef KEY_LOCK_EN
        exp_key  = 6'h2D;
        exp_busy = 1'b0;
`else
        exp_key  = 6'h33;
        exp_busy = 1'b1;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        send_frame(6'b101101, 1'b0);
        checks++; if (key !== 6'h2D) begin errors++; $display("FAIL lk_first_key got=%h exp=2d", key); end
        do_start();
        checks++; if (busy !== exp_busy) begin errors++; $display("FAIL lk_busy_after_start got=%b exp=%b", busy, exp_busy); end
        send_frame(6'b110011, 1'b0);
        checks++; if (key !== exp_key) begin errors++; $display("FAIL lk_key got=%h exp=%h", key, exp_key); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lk_busy_end got=%b exp=0", busy); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL lk_ready got=%b exp=1", key_ready); end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        key_strobe = 1'b0;
        key_bit    = 1'b0;
        #2;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_timeout();
        test_restart();
        test_mid_reset();
        test_reload_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
